// File: rtl/mod7_serial_tx.sv
// Mod-7 residue serial link transmitter: LSB-first payload followed by 3 check bits
// that zero the frame residue. Optional check-bit error injection: MOD7_SERIAL_TX_ERRINJ_EN.
module mod7_serial_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef MOD7_SERIAL_TX_ERRINJ_EN
    input  logic              err_inj,
`endif
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              sof,
    output logic              chk,
    output logic [2:0]        phase,
    output logic [2:0]        residue
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CHK  = 6'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Residue addition: 4-bit sum with end-around carry, 7 folds to 0.
    function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        logic [2:0] fold;
        sum  = {1'b0, a} + {1'b0, b};
        fold = sum[2:0] + {2'b00, sum[3]};
        if (fold == 3'd7) begin
            return 3'd0;
        end else begin
            return fold;
        end
    endfunction

    function automatic logic [2:0] mod7_neg(input logic [2:0] a);
        if (a == 3'd0) begin
            return 3'd0;
        end else begin
            return 3'd7 - a;
        end
    endfunction

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_residue;
    logic [2:0]        r_n;
    logic [2:0]        r_phase;
    logic              r_inj;
    logic              r_in_ready;
    logic              r_ser_out;
    logic              r_ser_valid;
    logic              r_sof;
    logic              r_chk;

    state_t            w_nxt_state;
    logic [DATA_W-1:0] w_nxt_shift;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [2:0]        w_nxt_residue;
    logic [2:0]        w_nxt_n;
    logic [2:0]        w_nxt_phase;
    logic              w_nxt_inj;
    logic              w_nxt_ser_out;
    logic [2:0]        w_res_fin;
    logic              w_inj_in;

`ifdef MOD7_SERIAL_TX_ERRINJ_EN
    assign w_inj_in = err_inj;
`else
    assign w_inj_in = 1'b0;
`endif

    assign w_nxt_phase = {r_phase[1:0], r_phase[2]};
    assign w_res_fin   = r_shift[0] ? mod7_add(r_residue, r_phase) : r_residue;

    // Frame sequencing: next state and datapath values.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_shift   = r_shift;
        w_nxt_cnt     = r_cnt;
        w_nxt_residue = r_residue;
        w_nxt_n       = r_n;
        w_nxt_inj     = r_inj;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_nxt_state   = ST_DATA;
                    w_nxt_shift   = in_data;
                    w_nxt_cnt     = {CNT_W{1'b0}};
                    w_nxt_residue = 3'd0;
                    w_nxt_inj     = w_inj_in;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                w_nxt_shift   = r_shift >> 1;
                w_nxt_residue = w_res_fin;
                if (r_cnt == LAST_DATA) begin
                    w_nxt_state = ST_CHECK;
                    w_nxt_cnt   = {CNT_W{1'b0}};
                    w_nxt_n     = mod7_neg(w_res_fin);
                end else begin
                    w_nxt_cnt = r_cnt + 6'd1;
                end
            end
            ST_CHECK: begin
                if (r_cnt == LAST_CHK) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = {CNT_W{1'b0}};
                end else begin
                    w_nxt_cnt = r_cnt + 6'd1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Serial bit for the coming cycle; a check bit carries the n bit matching its weight.
    always_comb begin
        w_nxt_ser_out = 1'b0;
        case (w_nxt_state)
            ST_DATA: begin
                w_nxt_ser_out = w_nxt_shift[0];
            end
            ST_CHECK: begin
                w_nxt_ser_out = (|(w_nxt_n & w_nxt_phase)) ^ (w_nxt_inj & w_nxt_phase[0]);
            end
            default: begin
                w_nxt_ser_out = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= {DATA_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_residue <= 3'd0;
            r_n       <= 3'd0;
            r_phase   <= 3'b001;
            r_inj     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_shift   <= w_nxt_shift;
            r_cnt     <= w_nxt_cnt;
            r_residue <= w_nxt_residue;
            r_n       <= w_nxt_n;
            r_phase   <= w_nxt_phase;
            r_inj     <= w_nxt_inj;
        end
    end

    // Output registers decoded from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_chk       <= 1'b0;
        end else begin
            r_in_ready  <= (w_nxt_state == ST_IDLE);
            r_ser_out   <= w_nxt_ser_out;
            r_ser_valid <= (w_nxt_state != ST_IDLE);
            r_sof       <= (w_nxt_state == ST_DATA) && (w_nxt_cnt == {CNT_W{1'b0}});
            r_chk       <= (w_nxt_state == ST_CHECK);
        end
    end

    assign in_ready  = r_in_ready;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign sof       = r_sof;
    assign chk       = r_chk;
    assign phase     = r_phase;
    assign residue   = r_residue;

endmodule

// File: tb/tb_mod7_serial_tx.sv
// Bench for mod7_serial_tx: frame-level queue model checked every cycle plus
// hand-computed frames (DATA_W=8). Error-injection test with MOD7_SERIAL_TX_ERRINJ_EN.
module tb_mod7_serial_tx;

    localparam int DATA_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       err_inj;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       sof;
    logic       chk;
    logic [2:0] phase;
    logic [2:0] residue;

    int n_err = 0;
    int n_chk = 0;

    mod7_serial_tx #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef MOD7_SERIAL_TX_ERRINJ_EN
        .err_inj   (err_inj),
`endif
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .sof       (sof),
        .chk       (chk),
        .phase     (phase),
        .residue   (residue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ser_out;
        logic       sof;
        logic       chk;
        logic [2:0] res;
    } ent_t;

    ent_t q[$];
    logic cap[$];
    int   sof_times[$];

    int         t = 0;
    logic       model_on = 1'b0;
    logic       e_ready, e_valid, e_out, e_sof, e_chk;
    logic [2:0] e_res;
    logic [2:0] m_res;
    int         m_frame_res = 0;
    int         chk_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] wt(input int tt);
        logic [2:0] one;
        one = 3'b001;
        return one << (tt % 3);
    endfunction

    // Expected frame: payload bits then 3 check bits, weights from the absolute cycle index.
    task automatic build_frame(input logic [7:0] d, input logic inj);
        int   r;
        int   w;
        int   n;
        ent_t e;
        r = 0;
        for (int i = 0; i < DATA_W; i++) begin
            w = int'(wt(t + i));
            e.ser_out = d[i];
            e.sof = (i == 0);
            e.chk = 1'b0;
            e.res = 3'(r);
            q.push_back(e);
            if (d[i]) r = (r + w) % 7;
        end
        n = (7 - r) % 7;
        for (int j = 0; j < 3; j++) begin
            w = int'(wt(t + DATA_W + j));
            e.ser_out = ((n & w) != 0) ^ (inj && (w == 1));
            e.sof = 1'b0;
            e.chk = 1'b1;
            e.res = 3'(r);
            q.push_back(e);
        end
        m_res = 3'(r);
        m_frame_res = !inj ? 0 : (((n % 2) == 1) ? 6 : 1);
    endtask

    initial begin : model
        ent_t ent;
        logic inj_now;
        forever begin
            @(posedge clk);
            if (rst) begin
                t = 0;
                q.delete();
                m_res = 3'd0;
                model_on = 1'b1;
                e_ready = 1'b1; e_valid = 1'b0; e_out = 1'b0;
                e_sof = 1'b0; e_chk = 1'b0; e_res = 3'd0;
            end else if (model_on) begin
                t = t + 1;
`ifdef MOD7_SERIAL_TX_ERRINJ_EN
                inj_now = err_inj;
`else
                inj_now = 1'b0;
`endif
                if (e_ready && in_valid) build_frame(in_data, inj_now);
                if (q.size() > 0) begin
                    ent = q.pop_front();
                    e_ready = 1'b0; e_valid = 1'b1; e_out = ent.ser_out;
                    e_sof = ent.sof; e_chk = ent.chk; e_res = ent.res;
                end else begin
                    e_ready = 1'b1; e_valid = 1'b0; e_out = 1'b0;
                    e_sof = 1'b0; e_chk = 1'b0; e_res = m_res;
                end
            end
        end
    end

    initial begin : compare
        int acc;
        int nchk;
        int cyc;
        acc = 0; nchk = 0; cyc = 0;
        forever begin
            @(negedge clk);
            if (model_on) begin
                cyc++;
                check("in_ready", 32'(in_ready), 32'(e_ready));
                check("ser_valid", 32'(ser_valid), 32'(e_valid));
                check("ser_out", 32'(ser_out), 32'(e_out));
                check("sof", 32'(sof), 32'(e_sof));
                check("chk", 32'(chk), 32'(e_chk));
                check("phase", 32'(phase), 32'(wt(t)));
                check("residue", 32'(residue), 32'(e_res));
                if (sof) begin
                    acc = 0;
                    nchk = 0;
                    sof_times.push_back(cyc);
                end
                if (ser_valid && ser_out) acc = (acc + int'(wt(t))) % 7;
                if (ser_valid) cap.push_back(ser_out);
                if (chk) begin
                    nchk++;
                    chk_total++;
                    if (nchk == 3) check("frame_residue", 32'(acc), 32'(m_frame_res));
                end
            end
        end
    end

    task automatic frame_test(input string nm, input logic [7:0] d, input logic inj,
                              input logic [10:0] exp_bits, input logic [2:0] exp_res);
        logic [10:0] v;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        err_inj = inj;
        cap.delete();
        @(negedge clk);
        in_valid = 1'b0;
        err_inj = 1'b0;
        in_data = ~d;
        repeat (12) @(negedge clk);
        v = 11'd0;
        for (int i = 0; i < cap.size() && i < 11; i++) v[i] = cap[i];
        check({nm, "_len"}, 32'(cap.size()), 32'd11);
        check({nm, "_bits"}, 32'(v), 32'(exp_bits));
        check({nm, "_residue"}, 32'(residue), 32'(exp_res));
        check({nm, "_gap_valid"}, 32'(ser_valid), 32'd0);
    endtask

    task automatic send(input logic [7:0] d);
        int k;
        in_data = d;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("send_timeout", 32'(k), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : stim
        int chk_before;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        err_inj = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_phase", 32'(phase), 32'd1);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_residue", 32'(residue), 32'd0);

        frame_test("f01", 8'h01, 1'b0, 11'h501, 3'd2);
        frame_test("fff", 8'hFF, 1'b0, 11'h1FF, 3'd6);
        frame_test("f00", 8'h00, 1'b0, 11'h000, 3'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sof_times.delete();
        send(8'h5A);
        send(8'hA5);
        repeat (14) @(negedge clk);
        check("b2b_sof_count", 32'(sof_times.size()), 32'd2);
        if (sof_times.size() == 2) check("b2b_spacing", 32'(sof_times[1] - sof_times[0]), 32'd12);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h5A);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_before = chk_total;
        @(negedge clk);
        check("abort_ser_valid", 32'(ser_valid), 32'd0);
        check("abort_ser_out", 32'(ser_out), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_phase", 32'(phase), 32'd1);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_check_bits", 32'(chk_total), 32'(chk_before));
        check("abort_residue", 32'(residue), 32'd0);

`ifdef MOD7_SERIAL_TX_ERRINJ_EN
        frame_test("finj", 8'h01, 1'b1, 11'h401, 3'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mod7_serial_tx.md
Name: mod7_serial_tx

Overview:
- Transmit end of the mod-7 residue serial link.
- Accepts a parallel word through a valid/ready handshake and shifts it out LSB-first on a single bit line, one bit per clock.
- Appends 3 check bits so that the mod-7 residue of the whole frame is 0. Bit weights follow the same free-running 1→2→4 phase rotation the residue receiver chain uses.
- Sits upstream of the divider cell chain. Also serves as its stimulus source in system benches.

Parameters:
- DATA_W, 8, payload width in bits; legal range 1..32.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_W  payload word.
- in_valid  input  1  payload offered.
- in_ready  output  1  block can accept a payload this cycle.
- ser_out  output  1  serial bit; 0 when idle.
- ser_valid  output  1  ser_out carries a frame bit (payload or check).
- sof  output  1  high with payload bit 0 only.
- chk  output  1  high during the 3 check-bit cycles.
- phase  output  3  current one-hot bit weight: 001, 010 or 100.
- residue  output  3  running payload residue mod 7, range 0..6.

Behaviour:
- Single clock; every register is updated only on posedge clk. rst is sampled synchronously and is active-high.
- Reset values:
  - phase=001, state=IDLE.
  - in_ready=1, ser_out=0, ser_valid=0, sof=0, chk=0, residue=0.
- Phase:
  - Free-running; rotates 001→010→100→001 on every clock after reset, independent of state.
  - Value 001 in the first cycle after rst deasserts.
  - The weight of any emitted bit is the phase value in the cycle that bit is on ser_out.
- States: IDLE, DATA, CHECK.
- IDLE:
  - in_ready=1, ser_valid=0, ser_out=0.
  - in_valid&in_ready latches in_data into the shift register, clears residue to 0 and goes to DATA.
  - Latency: payload bit 0 appears on ser_out in the cycle after the accept.
- DATA: DATA_W cycles.
  - ser_out=shift[0], ser_valid=1, in_ready=0.
  - sof=1 in the first DATA cycle only.
  - The register shifts right each cycle.
  - When ser_out=1: residue ← (residue + weight) mod 7. Implemented as a 4-bit sum with end-around carry; a result of 7 folds to 0. Residue never holds 7.
  - On the last DATA cycle, latch n = (7 − residue_final) mod 7, where residue_final includes that bit. residue 0 gives n=0. Then go to CHECK.
- CHECK: exactly 3 cycles.
  - chk=1, ser_valid=1, in_ready=0.
  - ser_out = n[0] when phase=001, n[1] when phase=010, n[2] when phase=100.
  - Three consecutive cycles cover each weight once, so the check contributes exactly n.
  - After the 3rd cycle, return to IDLE.
- Frame invariant: a receiver-chain model summing the weights of all 1-bits in the frame, mod 7, yields 0 for every frame, for any DATA_W and any start phase.
- Minimum gap: one IDLE cycle between frames (ser_valid=0, ser_out=0).
- Held input:
  - in_valid while busy is ignored; the source must hold in_data and in_valid until in_ready.
  - in_data is sampled only at accept; later changes do not affect the frame.
- Reset asserted mid-frame aborts the frame: no further bits and no check bits; all outputs return to reset values next cycle.
- residue holds its last value in IDLE until the next accept.

Optional Feature:
- Macro MOD7_SERIAL_TX_ERRINJ_EN.
- Defined:
  - Adds input err_inj (1 bit), sampled at accept and stored with the frame.
  - If it was 1, the check bit emitted at phase 001 is inverted, so the frame residue is nonzero. Bits emitted at the other two phases are unaffected.
- Undefined: port absent; check bits always correct.

Test Plan (DATA_W=8; accept in first cycle after reset, so payload phases are 010,100,001,010,100,001,010,100 and check phases are 001,010,100):
- in_data=0x01 → payload 1,0,0,0,0,0,0,0; residue=2, n=5; check ser_out=1,0,1; sof with bit 0; chk high for 3 cycles.
- in_data=0xFF → residue=20 mod 7=6, n=1; check 1,0,0. Receiver model sum=21≡0.
- in_data=0x00 → residue=0, n=0; check 0,0,0; ser_valid high for 11 cycles, then IDLE.
- in_valid held high with 0x5A then 0xA5 → frames separated by exactly 1 IDLE cycle. in_ready=0 for the 11 busy cycles, 1 in the gap. Each frame passes the residue-0 check.
- rst pulsed in 4th DATA cycle → next cycle ser_valid=0, ser_out=0, in_ready=1, phase=001; no check bits emitted.
- With MOD7_SERIAL_TX_ERRINJ_EN, in_data=0x01 and err_inj=1 at accept → check 0,0,1; receiver residue=6.
